ex_mem_stage: RTL and testbench

//  EX->MEM pipeline stage directly downstream of the ALU (ALU_top). Captures the ALU

---
 rtl/ex_mem_stage.sv | 177 +++++++++++++++++
 tb/tb_ex_mem_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: 2-entry skid buffer with valid/ready handshakes,
// flush, and a saturating overflow counter. Define EX_MEM_OVF_TRAP_EN to enable precise overflow traps.
module ex_mem_stage #(
    parameter int DW = 64,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_result,
    input  logic          in_zero,
    input  logic          in_overflow,
    input  logic [RW-1:0] in_rd,
    input  logic          in_reg_write,
    input  logic          in_mem_read,
    input  logic          in_mem_write,
    input  logic [DW-1:0] in_store_data,
    input  logic [DW-1:0] in_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic          out_zero,
    output logic          out_overflow,
    output logic [RW-1:0] out_rd,
    output logic          out_reg_write,
    output logic          out_mem_read,
    output logic          out_mem_write,
    output logic [DW-1:0] out_store_data,
    output logic [DW-1:0] out_pc,
    output logic [CW-1:0] ovf_count,
    output logic          trap,
    output logic [DW-1:0] trap_pc,
    input  logic          trap_ack
);

    typedef struct packed {
        logic [DW-1:0] result;
        logic          zero;
        logic          overflow;
        logic [RW-1:0] rd;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic [DW-1:0] store_data;
        logic [DW-1:0] pc;
    } entry_t;

    typedef enum logic {RUN, TRAP} state_t;

    entry_t        head_q, head_d, skid_q, skid_d, in_entry;
    logic [1:0]    count_q, count_d;
    logic [CW-1:0] ovf_count_q, ovf_count_d;
    state_t        state_q, state_d;
    logic          trap_q, trap_d;
    logic [DW-1:0] trap_pc_q, trap_pc_d;
    logic          push, pop;

    assign in_ready  = (count_q != 2'd2) && (state_q == RUN);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        in_entry.result     = in_result;
        in_entry.zero       = in_zero;
        in_entry.overflow   = in_overflow;
        in_entry.rd         = in_rd;
        in_entry.reg_write  = in_reg_write;
        in_entry.mem_read   = in_mem_read;
        in_entry.mem_write  = in_mem_write;
        in_entry.store_data = in_store_data;
        in_entry.pc         = in_pc;
`ifdef EX_MEM_OVF_TRAP_EN
        // The trapping instruction must not retire any architectural side effect.
        if (in_overflow) begin
            in_entry.reg_write = 1'b0;
            in_entry.mem_write = 1'b0;
        end
`endif
    end

    // Head lives in its own register so out_* hold the last popped entry when empty.
    always_comb begin
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = in_entry;
                    else                 skid_d = in_entry;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) head_d = skid_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: head_d = in_entry;
                default: ;
            endcase
        end
    end

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (push && in_overflow && (ovf_count_q != {CW{1'b1}}))
            ovf_count_d = ovf_count_q + CW'(1);
    end

`ifdef EX_MEM_OVF_TRAP_EN
    always_comb begin
        state_d   = state_q;
        trap_d    = trap_q;
        trap_pc_d = trap_pc_q;
        case (state_q)
            RUN: if (push && in_overflow) begin
                state_d   = TRAP;
                trap_d    = 1'b1;
                trap_pc_d = in_pc;
            end
            TRAP: if (trap_ack) begin
                state_d = RUN;
                trap_d  = 1'b0;
            end
            default: state_d = RUN;
        endcase
    end
`else
    logic unused_trap_ack;
    assign unused_trap_ack = trap_ack;

    always_comb begin
        state_d   = RUN;
        trap_d    = 1'b0;
        trap_pc_d = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            skid_q      <= '0;
            count_q     <= 2'd0;
            ovf_count_q <= '0;
            state_q     <= RUN;
            trap_q      <= 1'b0;
            trap_pc_q   <= '0;
        end else begin
            head_q      <= head_d;
            skid_q      <= skid_d;
            count_q     <= count_d;
            ovf_count_q <= ovf_count_d;
            state_q     <= state_d;
            trap_q      <= trap_d;
            trap_pc_q   <= trap_pc_d;
        end
    end

    assign out_result     = head_q.result;
    assign out_zero       = head_q.zero;
    assign out_overflow   = head_q.overflow;
    assign out_rd         = head_q.rd;
    assign out_reg_write  = head_q.reg_write;
    assign out_mem_read   = head_q.mem_read;
    assign out_mem_write  = head_q.mem_write;
    assign out_store_data = head_q.store_data;
    assign out_pc         = head_q.pc;
    assign ovf_count      = ovf_count_q;
    assign trap           = trap_q;
    assign trap_pc        = trap_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage; uses a narrow overflow counter so saturation is reachable.
module tb_ex_mem_stage;
    localparam int DW = 64;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam logic [CW-1:0] OVF_MAX = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, in_zero, in_overflow;
    logic [DW-1:0] in_result, in_store_data, in_pc;
    logic [RW-1:0] in_rd;
    logic          in_reg_write, in_mem_read, in_mem_write;
    logic          out_valid, out_ready, out_zero, out_overflow;
    logic [DW-1:0] out_result, out_store_data, out_pc;
    logic [RW-1:0] out_rd;
    logic          out_reg_write, out_mem_read, out_mem_write;
    logic [CW-1:0] ovf_count;
    logic          trap, trap_ack;
    logic [DW-1:0] trap_pc;

    ex_mem_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_zero(in_zero), .in_overflow(in_overflow), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_store_data(in_store_data), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_overflow(out_overflow), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_store_data(out_store_data), .out_pc(out_pc),
        .ovf_count(ovf_count), .trap(trap), .trap_pc(trap_pc), .trap_ack(trap_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] result;
        logic [RW-1:0] rd;
        logic          rw;
        logic          mw;
        logic [DW-1:0] sd;
        logic [DW-1:0] pc;
    } exp_t;

    exp_t          sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] mdl_ovf = '0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [DW-1:0] res, input logic [RW-1:0] rd,
                       input logic rw, input logic mw, input logic ovf, input logic [DW-1:0] pc);
        in_valid      = v;
        in_result     = res;
        in_rd         = rd;
        in_reg_write  = rw;
        in_mem_write  = mw;
        in_overflow   = ovf;
        in_pc         = pc;
        in_store_data = ~res;
    endtask

    // Negedge monitor: handshakes seen here are the ones the next rising edge commits.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb_q.delete();
            mdl_ovf = '0;
        end else begin
            if (in_valid && in_ready && in_overflow && mdl_ovf != OVF_MAX) mdl_ovf = mdl_ovf + 1'b1;
            if (flush) begin
                sb_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
                    else begin
                        e = sb_q.pop_front();
                        chk("sb_result", out_result, e.result);
                        chk("sb_rd", DW'(out_rd), DW'(e.rd));
                        chk("sb_reg_write", DW'(out_reg_write), DW'(e.rw));
                        chk("sb_mem_write", DW'(out_mem_write), DW'(e.mw));
                        chk("sb_store_data", out_store_data, e.sd);
                        chk("sb_pc", out_pc, e.pc);
                    end
                end
                if (in_valid && in_ready) begin
                    e.result = in_result;
                    e.rd     = in_rd;
                    e.sd     = in_store_data;
                    e.pc     = in_pc;
`ifdef EX_MEM_OVF_TRAP_EN
                    e.rw = in_reg_write && !in_overflow;
                    e.mw = in_mem_write && !in_overflow;
`else
                    e.rw = in_reg_write;
                    e.mw = in_mem_write;
`endif
                    sb_q.push_back(e);
                end
            end
        end
    end

    task automatic push1(input logic [DW-1:0] res, input logic ovf, input logic [DW-1:0] pc);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk("push_timeout", 0, 1);
        drv(1'b1, res, 5'd3, 1'b1, 1'b0, ovf, pc);
        step();
        drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
`ifdef EX_MEM_OVF_TRAP_EN
        if (ovf) begin
            chk("trap_raise", DW'(trap), 1);
            trap_ack = 1'b1;
            step();
            trap_ack = 1'b0;
            chk("trap_clear", DW'(trap), 0);
        end
`endif
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0; trap_ack = 1'b0;
        in_zero = 1'b0; in_mem_read = 1'b0;
        drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        step(); step();
        reset = 1'b0;
        // reset state
        chk("rst_out_valid", DW'(out_valid), 0);
        chk("rst_in_ready", DW'(in_ready), 1);
        chk("rst_out_result", out_result, 0);
        chk("rst_ovf_count", DW'(ovf_count), 0);
        chk("rst_trap", DW'(trap), 0);
        chk("rst_trap_pc", trap_pc, 0);

        // 1: single entry, one-cycle latency
        out_ready = 1'b1;
        drv(1'b1, 300, 5'd5, 1'b1, 1'b0, 1'b0, 64'h10);
        step();
        drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        chk("t1_valid", DW'(out_valid), 1);
        chk("t1_result", out_result, 300);
        chk("t1_rd", DW'(out_rd), 5);
        step();
        chk("t1_drained", DW'(out_valid), 0);

        // 2: backpressure, full buffer, ordered drain
        out_ready = 1'b0;
        drv(1'b1, 10, 5'd1, 1'b1, 1'b0, 1'b0, 64'h20); step();
        drv(1'b1, 20, 5'd2, 1'b1, 1'b0, 1'b0, 64'h24); step();
        chk("t2_full_ready", DW'(in_ready), 0);
        chk("t2_head", out_result, 10);
        drv(1'b1, 30, 5'd3, 1'b1, 1'b1, 1'b0, 64'h28); step(); step();
        chk("t2_still_full", DW'(in_ready), 0);
        out_ready = 1'b1; step();
        chk("t2_pop1", out_result, 20);
        chk("t2_ready_back", DW'(in_ready), 1);
        step();
        chk("t2_pushpop", out_result, 30);
        drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        step();
        chk("t2_empty", DW'(out_valid), 0);

        // 3: push and pop in the same cycle at count=1
        out_ready = 1'b0;
        push1(7, 1'b0, 64'h30);
        drv(1'b1, 8, 5'd8, 1'b0, 1'b1, 1'b0, 64'h34);
        out_ready = 1'b1; step();
        drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        out_ready = 1'b0;
        chk("t3_valid", DW'(out_valid), 1);
        chk("t3_result", out_result, 8);
        step();
        chk("t3_count1_valid", DW'(out_valid), 1);
        chk("t3_count1_ready", DW'(in_ready), 1);
        out_ready = 1'b1; step();
        chk("t3_drained", DW'(out_valid), 0);

        // 4: flush of a full buffer with input pending
        out_ready = 1'b0;
        drv(1'b1, 40, 5'd4, 1'b1, 1'b0, 1'b0, 64'h40); step();
        drv(1'b1, 41, 5'd4, 1'b1, 1'b0, 1'b0, 64'h44); step();
        chk("t4_full", DW'(in_ready), 0);
        drv(1'b1, 99, 5'd9, 1'b1, 1'b0, 1'b0, 64'h48);
        flush = 1'b1; step();
        flush = 1'b0;
        drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        chk("t4_flush_valid", DW'(out_valid), 0);
        chk("t4_flush_ready", DW'(in_ready), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_nothing_later", DW'(out_valid), 0);
        end
`ifndef EX_MEM_OVF_TRAP_EN
        // a push coinciding with flush still counts its overflow
        drv(1'b1, 55, 5'd1, 1'b1, 1'b0, 1'b1, 64'h4c);
        flush = 1'b1; step();
        flush = 1'b0;
        drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        chk("t4_flush_ovf", DW'(ovf_count), 1);
        chk("t4_flush_ovf_valid", DW'(out_valid), 0);
`endif

        // 5: overflow counting and saturation
        begin
            logic [CW-1:0] base;
            base = mdl_ovf;
            for (int i = 0; i < 3; i++) push1(64'(100 + i), 1'b1, 64'(16'h100 + 4 * i));
            step();
            chk("t5_ovf3", DW'(ovf_count), DW'(base + 3));
        end
        while (mdl_ovf < OVF_MAX - 1) push1(64'h200, 1'b1, 64'h200);
        step();
        chk("t5_preload", DW'(ovf_count), DW'(OVF_MAX - 1));
        push1(64'h201, 1'b1, 64'h204);
        push1(64'h202, 1'b1, 64'h208);
        step();
        chk("t5_saturate", DW'(ovf_count), DW'(OVF_MAX));
        push1(64'h203, 1'b0, 64'h20c);
        step();
        chk("t5_no_ovf_hold", DW'(ovf_count), DW'(OVF_MAX));

        // 6: overflow entry with side effects
        out_ready = 1'b0;
        drv(1'b1, 64'h77, 5'd7, 1'b1, 1'b1, 1'b1, 64'h40); step();
        drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        chk("t6_valid", DW'(out_valid), 1);
`ifdef EX_MEM_OVF_TRAP_EN
        chk("t6_trap", DW'(trap), 1);
        chk("t6_trap_pc", trap_pc, 64'h40);
        chk("t6_reg_write", DW'(out_reg_write), 0);
        chk("t6_mem_write", DW'(out_mem_write), 0);
        chk("t6_in_ready", DW'(in_ready), 0);
        flush = 1'b1; step(); flush = 1'b0;
        chk("t6_flush_keeps_trap", DW'(trap), 1);
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        chk("t6_ack_trap", DW'(trap), 0);
        chk("t6_ack_ready", DW'(in_ready), 1);
        chk("t6_trap_pc_hold", trap_pc, 64'h40);
`else
        chk("t6_trap", DW'(trap), 0);
        chk("t6_trap_pc", trap_pc, 0);
        chk("t6_reg_write", DW'(out_reg_write), 1);
        chk("t6_mem_write", DW'(out_mem_write), 1);
        chk("t6_in_ready", DW'(in_ready), 1);
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        chk("t6_ack_ignored", DW'(trap), 0);
`endif
        out_ready = 1'b1;
        step(); step();
        chk("end_out_valid", DW'(out_valid), 0);
        chk("end_sb_empty", DW'(sb_q.size()), 0);
        chk("end_ovf_model", DW'(ovf_count), DW'(mdl_ovf));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
